// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Package : seg7_pkg
// Purpose : Shared types and constants for the 2-digit 7-segment count display:
//           BCD engine state encoding, active-high segment patterns for the
//           decimal digits and a nibble-to-segment decode helper.
// Revision: 1.0  initial release
// ============================================================================
package seg7_pkg;

  // BCD conversion engine states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_t;

  // Segment order {g,f,e,d,c,b,a}, bit0 = a, 1 = segment lit
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Number of shift steps needed for a 6-bit binary input
  localparam int BIN_W = 6;

  // Nibbles 10..15 are not decimal digits and render dark
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    if (digit <= 4'd9) begin
      return SEG_DIGIT[digit];
    end
    return SEG_OFF;
  endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_count_display_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Purpose : Sequential shift-add-3 (double dabble) converter, 6-bit binary to
//           two BCD digits, one shift per clock.
// Ports   : clk   in  1  system clock
//           reset in  1  asynchronous, active-low reset
//           start in  1  request a conversion (accepted only while idle)
//           bin   in  6  binary value captured on an accepted start
//           tens  out 4  tens nibble of the working register
//           ones  out 4  ones nibble of the working register
//           busy  out 1  high while a conversion is in progress
//           done  out 1  one-cycle pulse; tens/ones hold the final result
// Revision: 1.0  initial release
// ============================================================================
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       done
);

  bcd_state_t  state;
  bcd_state_t  state_next;
  logic [13:0] sh;        // {tens[3:0], ones[3:0], bin[5:0]}
  logic [13:0] sh_next;
  logic [2:0]  it;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (it == 3'(BIN_W - 1)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // One double-dabble step: correct each BCD nibble >= 5, then shift left
  always_comb begin
    logic [3:0] t_adj;
    logic [3:0] o_adj;
    t_adj   = sh[13:10];
    o_adj   = sh[9:6];
    if (t_adj >= 4'd5) t_adj = t_adj + 4'd3;
    if (o_adj >= 4'd5) o_adj = o_adj + 4'd3;
    sh_next = {t_adj[2:0], o_adj, sh[5:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh <= '0;
      it <= '0;
    end else if (state == ST_IDLE && start) begin
      sh <= {8'b0, bin};
      it <= '0;
    end else if (state == ST_SHIFT) begin
      sh <= sh_next;
      it <= it + 3'd1;
    end
  end

  assign tens = sh[13:10];
  assign ones = sh[9:6];

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/seg7_count_display.sv
`default_nettype none
// ============================================================================
// Module  : seg7_count_display
// Purpose : Registers the 6-bit event count, converts it to BCD with a
//           sequential engine and drives a 2-digit multiplexed common-anode
//           7-segment display with leading-zero blanking.
// Ports   : clk   in  1  system clock
//           reset in  1  asynchronous, active-low reset
//           value in  6  binary count to display (0..63)
//           blank in  1  1 = force all anodes and segments off
//           seg   out 7  segments {g,f,e,d,c,b,a}, bit0 = a
//           an    out 2  digit enables, an[0] = ones, an[1] = tens
//           busy  out 1  high while a conversion is in progress
// Revision: 1.0  initial release
// ============================================================================
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] value,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       busy
);

  localparam int               SCAN_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [6:0]       SEG_PIN_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]       AN_PIN_OFF  = SEG_ACT_LOW ? 2'b11 : 2'b00;

  logic [5:0]        value_q;
  logic [5:0]        shown;
  logic [3:0]        bcd_t;
  logic [3:0]        bcd_o;
  logic [3:0]        eng_tens;
  logic [3:0]        eng_ones;
  logic              eng_done;
  logic              start;
  logic [SCAN_W-1:0] scan_cnt;
  logic              dig_sel;
  logic              scan_wrap;
  logic [6:0]        seg_ah;
  logic [1:0]        an_ah;

  // Input stage and last-converted value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      shown   <= '0;
    end else begin
      value_q <= value;
      // shown tracks the value the engine actually accepted, so a change that
      // arrives mid-conversion is picked up by the next idle compare
      if (start && !busy) shown <= value_q;
    end
  end

  assign start = (value_q != shown);

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (value_q),
    .tens  (eng_tens),
    .ones  (eng_ones),
    .busy  (busy),
    .done  (eng_done)
  );

  // Both digits update on the same edge, so the display never shows a torn value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_t <= '0;
      bcd_o <= '0;
    end else if (eng_done) begin
      bcd_t <= eng_tens;
      bcd_o <= eng_ones;
    end
  end

  // Digit scan timer
  assign scan_wrap = (scan_cnt == SCAN_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      dig_sel  <= 1'b0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      dig_sel  <= ~dig_sel;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Active-high view of the next pin state; the wrap cycle is a dark gap
  // between digits to keep the outgoing pattern from ghosting
  always_comb begin
    seg_ah = SEG_OFF;
    an_ah  = 2'b00;
    if (!blank && !scan_wrap) begin
      if (dig_sel) begin
        an_ah  = 2'b10;
        seg_ah = (bcd_t == 4'd0) ? SEG_OFF : seg_decode(bcd_t);
      end else begin
        an_ah  = 2'b01;
        seg_ah = seg_decode(bcd_o);
      end
    end
  end

  // Pin registers with board polarity applied
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= SEG_PIN_OFF;
      an  <= AN_PIN_OFF;
    end else begin
      seg <= SEG_ACT_LOW ? ~seg_ah : seg_ah;
      an  <= SEG_ACT_LOW ? ~an_ah  : an_ah;
    end
  end

endmodule : seg7_count_display
`default_nettype wire

// File: tb/tb_seg7_count_display.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_count_display
// Purpose : Directed self-checking bench for seg7_count_display with a short
//           scan period (4 cycles per digit slot), active-low pins.
// Revision: 1.0  initial release
// ============================================================================
module tb_seg7_count_display;

  logic       clk;
  logic       reset;
  logic [5:0] value;
  logic       blank;
  logic [6:0] seg;
  logic [1:0] an;
  logic       busy;

  int n_checks;
  int n_errors;
  int ecount;        // edges since reset release
  logic blank_last;  // blank as sampled at the most recent edge

  seg7_count_display #(
    .SCAN_DIV    (4),
    .SEG_ACT_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .blank (blank),
    .seg   (seg),
    .an    (an),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    blank_last = blank;
    @(posedge clk);
    #1;
    ecount++;
  endtask

  // Active-high segment patterns, written out independently of the design
  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Expected pins for the current edge, given the digits latched before it
  task automatic check_display(input string tag, input int tens, input int ones);
    int         ph;
    int         sl;
    logic [1:0] an_ah;
    logic [6:0] seg_ah;
    ph     = (ecount - 1) % 4;
    sl     = ((ecount - 1) / 4) % 2;
    an_ah  = 2'b00;
    seg_ah = 7'h00;
    if (ecount > 0 && !blank_last && ph != 3) begin
      if (sl == 0) begin
        an_ah  = 2'b01;
        seg_ah = ref_seg(ones);
      end else begin
        an_ah  = 2'b10;
        seg_ah = (tens == 0) ? 7'h00 : ref_seg(tens);
      end
    end
    check_value({tag, "_an"},  {30'b0, an},  {30'b0, ~an_ah});
    check_value({tag, "_seg"}, {25'b0, seg}, {25'b0, ~seg_ah});
    check_value({tag, "_both_on"}, {31'b0, an == 2'b00}, 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    ecount     = 0;
    blank_last = 1'b0;
    reset      = 1'b0;
    value      = 6'd0;
    blank      = 1'b0;

    // 1: reset state, then "0" in the ones slot with a dark tens slot
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_seg",  {25'b0, seg}, 32'h7F);
    check_value("rst_an",   {30'b0, an},  32'h3);
    check_value("rst_busy", {31'b0, busy}, 32'd0);
    reset  = 1'b1;
    ecount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_value("t1_busy", {31'b0, busy}, 32'd0);
      check_display("t1", 0, 0);
    end

    // 2: 0 -> 63; busy for 7 edges, result at k+8; also covers the scan sequence
    value = 6'd63;
    tick();
    check_value("t2_busy_k", {31'b0, busy}, 32'd0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_value("t2_busy", {31'b0, busy}, 32'd1);
    end
    tick();
    check_value("t2_busy_end", {31'b0, busy}, 32'd0);
    check_value("t2_bcd_t", {28'b0, dut.bcd_t}, 32'd6);
    check_value("t2_bcd_o", {28'b0, dut.bcd_o}, 32'd3);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_display("t2", 6, 3);
    end

    // 3: 9, 10, 11 on consecutive edges; 9 completes, then 11 is converted
    value = 6'd9;
    tick();
    value = 6'd10;
    tick();
    value = 6'd11;
    tick();
    repeat (6) tick();
    check_value("t3_bcd_t_9", {28'b0, dut.bcd_t}, 32'd0);
    check_value("t3_bcd_o_9", {28'b0, dut.bcd_o}, 32'd9);
    repeat (7) tick();
    check_value("t3_busy_11", {31'b0, busy}, 32'd1);
    tick();
    check_value("t3_bcd_t_11", {28'b0, dut.bcd_t}, 32'd1);
    check_value("t3_bcd_o_11", {28'b0, dut.bcd_o}, 32'd1);
    check_value("t3_idle", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_display("t3", 1, 1);
    end

    // 5: blank mid-scan for 20 cycles; scan phase must continue underneath
    tick();
    tick();
    blank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_display("t5_blank", 1, 1);
    end
    blank = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_display("t5_resume", 1, 1);
    end

    // 6: reset during SHIFT with value 47
    value = 6'd47;
    tick();
    tick();
    tick();
    tick();
    check_value("t6_busy_pre", {31'b0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_value("t6_busy_rst", {31'b0, busy}, 32'd0);
    check_value("t6_an_rst",   {30'b0, an},  32'h3);
    check_value("t6_seg_rst",  {25'b0, seg}, 32'h7F);
    check_value("t6_bcd_rst",  {24'b0, dut.bcd_t, dut.bcd_o}, 32'd0);
    reset  = 1'b1;
    ecount = 0;
    repeat (9) tick();
    check_value("t6_bcd_t", {28'b0, dut.bcd_t}, 32'd4);
    check_value("t6_bcd_o", {28'b0, dut.bcd_o}, 32'd7);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_display("t6", 4, 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_seg7_count_display
`default_nettype wire
